// File: rtl/psum_sched.sv
// Round-robin scheduler that shares one psum_acc among NUM_REQ producers: it stages one
// requester's ACC_NUM beats, replays them as a gap-free burst, then returns the tagged sum.
module psum_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ACC_NUM = 3,
    parameter int unsigned DW      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    output logic                       acc_en,
    output logic [DW-1:0]              acc_psum,
    input  logic [DW-1:0]              acc_sum,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DW-1:0]              res_data,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
    localparam logic [CW-1:0]  LastCnt = CW'(ACC_NUM - 1);
    localparam logic [IDW-1:0] LastId  = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {StIdle, StCollect, StBurst, StCapture, StResult} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  stage_q [ACC_NUM];
    logic [DW-1:0]  stage_d [ACC_NUM];
    logic [DW-1:0]  res_data_q, res_data_d;

    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;

    // Circular search for the first valid requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = (idx == LastId) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        req_ready  = '0;
        acc_en     = 1'b0;
        acc_psum   = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = pick;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                req_ready[gnt_q] = 1'b1;
                if (req_valid[gnt_q]) begin
                    stage_d[cnt_q] = req_data[32'(gnt_q) * DW +: DW];
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StBurst;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StBurst: begin
                acc_en   = 1'b1;
                acc_psum = stage_q[cnt_q];
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                // acc_sum still holds the full burst here; the accumulator clears on this edge.
                res_data_d = acc_sum;
                res_id_d   = gnt_q;
                state_d    = StResult;
            end
            StResult: begin
                if (res_ready) begin
                    rr_ptr_d = (gnt_q == LastId) ? '0 : gnt_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            for (int unsigned i = 0; i < ACC_NUM; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            stage_q    <= stage_d;
        end
    end

    assign res_valid = (state_q == StResult);
    assign busy      = (state_q != StIdle);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule
